// File: rtl/sram22_pipe_model.sv
// ---------------------------------------------------------------------------
// sram22_pipe_model: behavioural SRAM macro with post-reset clear sweep and
// a 1/2-stage registered read pipeline. Optional SRAM22_PARITY_EN adds
// per-lane even parity with error injection. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram22_pipe_model #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic                   ready,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid
`ifdef SRAM22_PARITY_EN
  ,
  input  logic [WMASK_WIDTH-1:0] par_flip,
  output logic                   parity_err
`endif
);

  localparam int LANE_W = DATA_WIDTH / WMASK_WIDTH;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_err_mask
    $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_lat
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [0:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   clearing;
  logic                   accept;
  logic                   rd_en;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [WMASK_WIDTH-1:0] wr_lanes;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [DATA_WIDTH-1:0]  rd_data;

  logic                   out_load;
  logic [DATA_WIDTH-1:0]  out_data;

`ifdef SRAM22_PARITY_EN
  logic [WMASK_WIDTH-1:0] par_mem_q [DEPTH];
  logic [WMASK_WIDTH-1:0] wr_par;
  logic                   rd_err;
  logic                   out_err;
  logic                   perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_READY;
      end
    end
  end

  // The clear sweep borrows the normal write port with a full-lane zero write.
  always_comb begin
    clearing = (state_q == ST_CLEAR);
    accept   = ce && (state_q == ST_READY);
    rd_en    = accept && !we;
    wr_en    = clearing || (accept && we);
    wr_addr  = clearing ? cnt_q : addr;
    wr_lanes = clearing ? {WMASK_WIDTH{1'b1}} : wmask;
    wr_data  = clearing ? {DATA_WIDTH{1'b0}} : din;
    rd_data  = mem_q[addr];
  end

`ifdef SRAM22_PARITY_EN
  always_comb begin
    wr_par = '0;
    rd_err = 1'b0;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      wr_par[i] = clearing ? 1'b0 : ((^din[i*LANE_W +: LANE_W]) ^ par_flip[i]);
      rd_err    = rd_err | ((^rd_data[i*LANE_W +: LANE_W]) ^ par_mem_q[addr][i]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wr_lanes[i]) begin
          mem_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
`ifdef SRAM22_PARITY_EN
          par_mem_q[wr_addr][i] <= wr_par[i];
`endif
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_vld_q, s1_vld_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
`ifdef SRAM22_PARITY_EN
    logic                  s1_err_q, s1_err_d;
`endif

    always_comb begin
      s1_vld_d  = rd_en;
      s1_data_d = rd_en ? rd_data : s1_data_q;
`ifdef SRAM22_PARITY_EN
      s1_err_d  = rd_en && rd_err;
`endif
    end

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        s1_vld_q  <= 1'b0;
        s1_data_q <= '0;
`ifdef SRAM22_PARITY_EN
        s1_err_q  <= 1'b0;
`endif
      end else begin
        s1_vld_q  <= s1_vld_d;
        s1_data_q <= s1_data_d;
`ifdef SRAM22_PARITY_EN
        s1_err_q  <= s1_err_d;
`endif
      end
    end

    assign out_load = s1_vld_q;
    assign out_data = s1_data_q;
`ifdef SRAM22_PARITY_EN
    assign out_err  = s1_err_q;
`endif
  end else begin : g_lat1
    assign out_load = rd_en;
    assign out_data = rd_data;
`ifdef SRAM22_PARITY_EN
    assign out_err  = rd_err;
`endif
  end

  always_comb begin
    dout_d       = out_load ? out_data : dout_q;
    dout_valid_d = out_load;
`ifdef SRAM22_PARITY_EN
    perr_d       = out_load && out_err;
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef SRAM22_PARITY_EN
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef SRAM22_PARITY_EN
      perr_q       <= perr_d;
`endif
    end
  end

  assign ready      = (state_q == ST_READY);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`ifdef SRAM22_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram22_pipe_model.sv
// ---------------------------------------------------------------------------
// tb_sram22_pipe_model: directed bench driving latency-1 and latency-2
// instances of sram22_pipe_model with identical stimulus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram22_pipe_model;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ce;
  logic        we;
  logic [3:0]  wmask;
  logic [8:0]  addr;
  logic [31:0] din;

  logic        rdy1, vld1, rdy2, vld2;
  logic [31:0] dout1, dout2;
`ifdef SRAM22_PARITY_EN
  logic [3:0]  par_flip;
  logic        perr1, perr2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram22_pipe_model #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .ready(rdy1), .dout(dout1), .dout_valid(vld1)
`ifdef SRAM22_PARITY_EN
    , .par_flip(par_flip), .parity_err(perr1)
`endif
  );

  sram22_pipe_model #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .ready(rdy2), .dout(dout2), .dout_valid(vld2)
`ifdef SRAM22_PARITY_EN
    , .par_flip(par_flip), .parity_err(perr2)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    ce = 1'b1; we = 1'b1; addr = a; din = d; wmask = m;
    tick();
    ce = 1'b0; we = 1'b0;
  endtask

  // Read one word; checks both latencies and the single-cycle valid pulse.
  task automatic rd(input string name, input logic [8:0] a, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; addr = a;
    tick();
    ce = 1'b0;
    checks++;
    if (dout1 !== exp || vld1 !== 1'b1) begin
      errors++;
      $display("FAIL %s lat1: dout=%h vld=%b expected %h/1", name, dout1, vld1, exp);
    end
    checks++;
    if (vld2 !== 1'b0) begin
      errors++;
      $display("FAIL %s lat2 early: vld=%b expected 0", name, vld2);
    end
`ifdef SRAM22_PARITY_EN
    checks++;
    if (perr1 !== 1'b0) begin
      errors++;
      $display("FAIL %s lat1 parity_err=%b expected 0", name, perr1);
    end
`endif
    tick();
    checks++;
    if (dout1 !== exp || vld1 !== 1'b0) begin
      errors++;
      $display("FAIL %s lat1 hold: dout=%h vld=%b expected %h/0", name, dout1, vld1, exp);
    end
    checks++;
    if (dout2 !== exp || vld2 !== 1'b1) begin
      errors++;
      $display("FAIL %s lat2: dout=%h vld=%b expected %h/1", name, dout2, vld2, exp);
    end
`ifdef SRAM22_PARITY_EN
    checks++;
    if (perr2 !== 1'b0) begin
      errors++;
      $display("FAIL %s lat2 parity_err=%b expected 0", name, perr2);
    end
`endif
    tick();
    checks++;
    if (dout2 !== exp || vld2 !== 1'b0) begin
      errors++;
      $display("FAIL %s lat2 hold: dout=%h vld=%b expected %h/0", name, dout2, vld2, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int  n = 0;
    logic saw = 1'b0;
    while (!(rdy1 && rdy2) && n < 600) begin
      if (vld1 || vld2) saw = 1'b1;
      n++;
      tick();
    end
    checks++;
    if (n != 512 || saw !== 1'b0) begin
      errors++;
      $display("FAIL %s clear: low cycles=%0d valid_seen=%b expected 512/0", name, n, saw);
    end
  endtask

  task automatic test_reset;
    rstb = 1'b1; ce = 1'b0; we = 1'b0; wmask = '0; addr = '0; din = '0;
`ifdef SRAM22_PARITY_EN
    par_flip = '0;
`endif
    #2 rstb = 1'b0;
    #1;
    tick();
    tick();
    checks++;
    if ({rdy1, vld1, rdy2, vld2} !== 4'b0000 || dout1 !== 32'h0 || dout2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b%b vld=%b%b dout=%h/%h expected all 0",
               rdy1, rdy2, vld1, vld2, dout1, dout2);
    end
    rstb = 1'b1; ce = 1'b1; we = 1'b0; addr = 9'h1FF;
    wait_ready("reset");
    rd("read_1ff_after_clear", 9'h1FF, 32'h0000_0000);
  endtask

  task automatic test_mask;
    wr(9'h005, 32'hDEAD_BEEF, 4'b1111);
    wr(9'h005, 32'h1122_3344, 4'b0101);
    rd("lane_mask", 9'h005, 32'hDE22_BE44);
  endtask

  task automatic test_wmask_zero;
    wr(9'h010, 32'h1234_5678, 4'b1111);
    rd("prime_dout", 9'h005, 32'hDE22_BE44);
    ce = 1'b1; we = 1'b1; addr = 9'h010; din = 32'hFFFF_FFFF; wmask = 4'b0000;
    tick();
    ce = 1'b0; we = 1'b0;
    checks++;
    if (dout1 !== 32'hDE22_BE44 || vld1 !== 1'b0 || dout2 !== 32'hDE22_BE44 || vld2 !== 1'b0) begin
      errors++;
      $display("FAIL write_hold_dout: dout=%h/%h vld=%b%b expected de22be44 vld 0",
               dout1, dout2, vld1, vld2);
    end
    rd("wmask_zero", 9'h010, 32'h1234_5678);
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    wr(9'h001, vals[0], 4'hF);
    wr(9'h002, vals[1], 4'hF);
    wr(9'h003, vals[2], 4'hF);
    ce = 1'b1; we = 1'b0; addr = 9'h001;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 2) addr = addr + 9'd1;
      else ce = 1'b0;
      checks++;
      if (k < 3) begin
        if (dout1 !== vals[k] || vld1 !== 1'b1) begin
          errors++;
          $display("FAIL b2b lat1 k=%0d: dout=%h vld=%b expected %h/1", k, dout1, vld1, vals[k]);
        end
      end else if (dout1 !== vals[2] || vld1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b lat1 k=%0d: dout=%h vld=%b expected %h/0", k, dout1, vld1, vals[2]);
      end
      checks++;
      if (k == 0) begin
        if (vld2 !== 1'b0) begin
          errors++;
          $display("FAIL b2b lat2 k=0: vld=%b expected 0", vld2);
        end
      end else if (k < 4) begin
        if (dout2 !== vals[k-1] || vld2 !== 1'b1) begin
          errors++;
          $display("FAIL b2b lat2 k=%0d: dout=%h vld=%b expected %h/1", k, dout2, vld2, vals[k-1]);
        end
      end else if (dout2 !== vals[2] || vld2 !== 1'b0) begin
        errors++;
        $display("FAIL b2b lat2 k=4: dout=%h vld=%b expected %h/0", dout2, vld2, vals[2]);
      end
    end
    // Read of 0x001 immediately followed by a write to it.
    ce = 1'b1; we = 1'b0; addr = 9'h001;
    tick();
    we = 1'b1; din = 32'h0000_0055; wmask = 4'hF;
    tick();
    ce = 1'b0; we = 1'b0;
    checks++;
    if (dout2 !== 32'hA || vld2 !== 1'b1) begin
      errors++;
      $display("FAIL war_lat2: dout=%h vld=%b expected 0000000a/1", dout2, vld2);
    end
    rd("raw_next_edge", 9'h001, 32'h0000_0055);
  endtask

  task automatic test_reset_mid;
    ce = 1'b1; we = 1'b0; addr = 9'h005;
    tick();
    ce = 1'b0;
    #2 rstb = 1'b0;
    #1;
    checks++;
    if ({rdy1, vld1, rdy2, vld2} !== 4'b0000 || dout1 !== 32'h0 || dout2 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b%b vld=%b%b dout=%h/%h expected all 0",
               rdy1, rdy2, vld1, vld2, dout1, dout2);
    end
    tick();
    tick();
    rstb = 1'b1;
    wait_ready("reset_mid");
    rd("cleared_005", 9'h005, 32'h0000_0000);
  endtask

`ifdef SRAM22_PARITY_EN
  task automatic test_parity;
    ce = 1'b1; we = 1'b1; addr = 9'h020; din = 32'h0000_00FF; wmask = 4'hF; par_flip = 4'b0001;
    tick();
    we = 1'b0; par_flip = 4'b0000;
    tick();
    ce = 1'b0;
    checks++;
    if (perr1 !== 1'b1 || vld1 !== 1'b1 || dout1 !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL parity_inject lat1: perr=%b vld=%b dout=%h expected 1/1/000000ff", perr1, vld1, dout1);
    end
    tick();
    checks++;
    if (perr1 !== 1'b0 || perr2 !== 1'b1 || vld2 !== 1'b1) begin
      errors++;
      $display("FAIL parity_inject lat2: perr1=%b perr2=%b vld2=%b expected 0/1/1", perr1, perr2, vld2);
    end
    tick();
    wr(9'h020, 32'h0000_00FF, 4'hF);
    rd("parity_clean", 9'h020, 32'h0000_00FF);
  endtask
`endif

  initial begin
    test_reset();
    test_mask();
    test_wmask_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef SRAM22_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
